// File: rtl/ins_exec_muldiv.sv
// M-extension multiply/divide execute unit. Iterative shift-add multiply and
// restoring divide, plus single-cycle paths for fast multiply and special divides.
module ins_exec_muldiv #(
  parameter int XLEN     = 32,
  parameter int FAST_MUL = 0
) (
  input  logic            sys_clk,
  input  logic            sys_rst_n,
  input  logic            op,
  input  logic [6:0]      ins_dec_op,
  input  logic [2:0]      ins_dec_funct3,
  input  logic [6:0]      ins_dec_funct7,
  input  logic [XLEN-1:0] reg_rs1_val,
  input  logic [XLEN-1:0] reg_rs2_val,
  input  logic [4:0]      reg_rd,
  input  logic            flush,
  output logic            busy,
  output logic            reg_w_op,
  output logic [4:0]      reg_w_reg_idx,
  output logic [XLEN-1:0] reg_w_reg_val
);

  // state | meaning
  // IDLE  | nothing in flight
  // CALC  | iterating, one multiplier / quotient bit per edge
  // DONE  | result registered, write-back strobe high this cycle

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [6:0] OPC_OP = 7'b0110011;
  localparam logic [6:0] F7_MD  = 7'b0000001;
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]     cnt_q;
  logic [2:0]        f3_q;
  logic [4:0]        rd_q;
  logic [XLEN-1:0]   a_q;
  logic [XLEN-1:0]   b_q;
  logic              neg_res_q;
  logic              neg_rem_q;
  logic [2*XLEN-1:0] acc_q;

  logic              accept;
  logic              is_mul_in;
  logic              a_sgn_in;
  logic              b_sgn_in;
  logic              a_neg_in;
  logic              b_neg_in;
  logic [XLEN-1:0]   a_mag_in;
  logic [XLEN-1:0]   b_mag_in;
  logic              div_zero_in;
  logic              ovf_in;
  logic              fast_in;
  logic [2*XLEN-1:0] fast_prod_mag;
  logic [2*XLEN-1:0] fast_prod;
  logic [XLEN-1:0]   fast_val;

  logic [XLEN-1:0]   mul_addend;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_trial;
  logic              div_ge;
  logic [2*XLEN-1:0] div_next;
  logic [2*XLEN-1:0] acc_next;
  logic [2*XLEN-1:0] iter_prod;
  logic [XLEN-1:0]   iter_quo;
  logic [XLEN-1:0]   iter_rem;
  logic [XLEN-1:0]   iter_val;

  logic              done_edge;
  logic [XLEN-1:0]   result_d;
  logic [4:0]        done_rd;
  logic              write_en;

  assign busy = (state_q == S_CALC);

  assign accept = op && (ins_dec_op == OPC_OP) && (ins_dec_funct7 == F7_MD) &&
                  ((state_q == S_IDLE) || (state_q == S_DONE)) && !flush;

  // Operand signedness: multiplies use funct3 0..3, divides 4..7 (odd = unsigned).
  assign is_mul_in = ~ins_dec_funct3[2];
  assign a_sgn_in  = is_mul_in ? (ins_dec_funct3 != 3'd3) : ~ins_dec_funct3[0];
  assign b_sgn_in  = is_mul_in ? ~ins_dec_funct3[1] : ~ins_dec_funct3[0];
  assign a_neg_in  = a_sgn_in & reg_rs1_val[XLEN-1];
  assign b_neg_in  = b_sgn_in & reg_rs2_val[XLEN-1];
  assign a_mag_in  = a_neg_in ? (~reg_rs1_val + 1'b1) : reg_rs1_val;
  assign b_mag_in  = b_neg_in ? (~reg_rs2_val + 1'b1) : reg_rs2_val;

  assign div_zero_in = ~is_mul_in && (reg_rs2_val == '0);
  assign ovf_in      = ~is_mul_in && ~ins_dec_funct3[0] &&
                       (reg_rs1_val == MOST_NEG) && (reg_rs2_val == ALL_ONES);
  assign fast_in     = (is_mul_in && (FAST_MUL != 0)) || div_zero_in || ovf_in;

  assign fast_prod_mag = {{XLEN{1'b0}}, a_mag_in} * {{XLEN{1'b0}}, b_mag_in};
  assign fast_prod     = (a_neg_in ^ b_neg_in) ? (~fast_prod_mag + 1'b1) : fast_prod_mag;

  always_comb begin
    fast_val = '0;
    if (is_mul_in) begin
      if (ins_dec_funct3 == 3'd0) fast_val = fast_prod[XLEN-1:0];
      else                        fast_val = fast_prod[2*XLEN-1:XLEN];
    end else if (div_zero_in) begin
      fast_val = ins_dec_funct3[1] ? reg_rs1_val : ALL_ONES;
    end else if (ovf_in) begin
      fast_val = ins_dec_funct3[1] ? '0 : MOST_NEG;
    end
  end

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right.
  assign mul_addend = acc_q[0] ? a_q : '0;
  assign mul_sum    = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, mul_addend};
  assign mul_next   = {mul_sum, acc_q[XLEN-1:1]};

  // Divide: acc = {partial remainder, dividend bits shifting into quotient}.
  assign div_trial = acc_q[2*XLEN-1:XLEN-1] - {1'b0, b_q};
  assign div_ge    = ~div_trial[XLEN];
  assign div_next  = {(div_ge ? div_trial[XLEN-1:0] : acc_q[2*XLEN-2:XLEN-1]),
                      acc_q[XLEN-2:0], div_ge};

  assign acc_next = f3_q[2] ? div_next : mul_next;

  assign iter_prod = neg_res_q ? (~mul_next + 1'b1) : mul_next;
  assign iter_quo  = neg_res_q ? (~div_next[XLEN-1:0] + 1'b1) : div_next[XLEN-1:0];
  assign iter_rem  = neg_rem_q ? (~div_next[2*XLEN-1:XLEN] + 1'b1) : div_next[2*XLEN-1:XLEN];

  always_comb begin
    iter_val = '0;
    case (f3_q)
      3'd0:          iter_val = iter_prod[XLEN-1:0];
      3'd1, 3'd2,
      3'd3:          iter_val = iter_prod[2*XLEN-1:XLEN];
      3'd4, 3'd5:    iter_val = iter_quo;
      default:       iter_val = iter_rem;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    done_edge = 1'b0;
    result_d  = '0;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (accept) begin
            if (fast_in) begin
              state_d   = S_DONE;
              done_edge = 1'b1;
              result_d  = fast_val;
            end else begin
              state_d = S_CALC;
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        S_CALC: begin
          if (cnt_q <= CW'(1)) begin
            state_d   = S_DONE;
            done_edge = 1'b1;
            result_d  = iter_val;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign done_rd  = accept ? reg_rd : rd_q;
  assign write_en = done_edge && (done_rd != 5'd0);

  always_ff @(negedge sys_clk) begin
    if (!sys_rst_n) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  always_ff @(negedge sys_clk) begin
    if (!sys_rst_n || flush) begin
      cnt_q         <= '0;
      reg_w_op      <= 1'b0;
      reg_w_reg_idx <= '0;
      reg_w_reg_val <= '0;
    end else begin
      if (accept) begin
        f3_q      <= ins_dec_funct3;
        rd_q      <= reg_rd;
        a_q       <= a_mag_in;
        b_q       <= b_mag_in;
        neg_res_q <= a_neg_in ^ b_neg_in;
        neg_rem_q <= a_neg_in;
        acc_q     <= is_mul_in ? {{XLEN{1'b0}}, b_mag_in} : {{XLEN{1'b0}}, a_mag_in};
        cnt_q     <= fast_in ? '0 : CW'(XLEN);
      end else if (state_q == S_CALC) begin
        acc_q <= acc_next;
        cnt_q <= cnt_q - CW'(1);
      end
      reg_w_op      <= write_en;
      reg_w_reg_idx <= write_en ? done_rd : '0;
      reg_w_reg_val <= write_en ? result_d : '0;
    end
  end

endmodule

// File: tb/tb_ins_exec_muldiv.sv
// Bench for ins_exec_muldiv: directed vector table, hand-built kill/pipeline
// sequences and random ops against an arithmetic reference model.
module tb_ins_exec_muldiv;

  localparam int XLEN     = 32;
  localparam int ITER_LAT = XLEN + 1;
  localparam logic [6:0]  OPC_OP = 7'b0110011;
  localparam logic [6:0]  F7_MD  = 7'b0000001;
  localparam logic [31:0] MIN    = 32'h8000_0000;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        op;
  logic [6:0]  ins_dec_op;
  logic [2:0]  ins_dec_funct3;
  logic [6:0]  ins_dec_funct7;
  logic [31:0] reg_rs1_val;
  logic [31:0] reg_rs2_val;
  logic [4:0]  reg_rd;
  logic        flush;

  logic        it_busy, it_wop, fm_busy, fm_wop;
  logic [4:0]  it_idx, fm_idx;
  logic [31:0] it_val, fm_val;

  always #5 sys_clk = ~sys_clk;

  ins_exec_muldiv #(.XLEN(XLEN), .FAST_MUL(0)) u_it (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .op(op), .ins_dec_op(ins_dec_op),
    .ins_dec_funct3(ins_dec_funct3), .ins_dec_funct7(ins_dec_funct7),
    .reg_rs1_val(reg_rs1_val), .reg_rs2_val(reg_rs2_val), .reg_rd(reg_rd),
    .flush(flush), .busy(it_busy), .reg_w_op(it_wop),
    .reg_w_reg_idx(it_idx), .reg_w_reg_val(it_val)
  );

  ins_exec_muldiv #(.XLEN(XLEN), .FAST_MUL(1)) u_fm (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .op(op), .ins_dec_op(ins_dec_op),
    .ins_dec_funct3(ins_dec_funct3), .ins_dec_funct7(ins_dec_funct7),
    .reg_rs1_val(reg_rs1_val), .reg_rs2_val(reg_rs2_val), .reg_rd(reg_rd),
    .flush(flush), .busy(fm_busy), .reg_w_op(fm_wop),
    .reg_w_reg_idx(fm_idx), .reg_w_reg_val(fm_val)
  );

  int n_pass  = 0;
  int n_total = 0;
  int dirty_total = 0;

  int          r_it_busy, r_it_wop, r_it_at, r_fm_wop, r_fm_at;
  logic [36:0] r_it_res, r_fm_res;
  logic [38:0] r_snap;
  logic [6:0]  opc_drive;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
    logic signed [63:0] sa, sb, ub;
    logic [63:0] p;
    logic [31:0] r;
    logic ovf;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ub  = {32'b0, b};
    ovf = (a == MIN) && (b == 32'hFFFF_FFFF);
    r   = '0;
    case (f3)
      3'd0: r = a * b;
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * ub; r = p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
      3'd4: r = (b == 0) ? 32'hFFFF_FFFF : (ovf ? MIN : 32'($signed(a) / $signed(b)));
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: r = (b == 0) ? a : (ovf ? 32'd0 : 32'($signed(a) % $signed(b)));
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return MIN;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 15));
      4: return 32'(-$urandom_range(1, 15));
      default: return $urandom;
    endcase
  endfunction

  // Issues one op at the current posedge, then samples max_cyc posedges.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int max_cyc, input int flush_at,
                        input int poke_at, input int rst_at, input int snap_at);
    op = 1'b1; ins_dec_op = opc_drive; ins_dec_funct7 = F7_MD;
    ins_dec_funct3 = f3; reg_rs1_val = a; reg_rs2_val = b; reg_rd = rd;
    r_it_busy = 0; r_it_wop = 0; r_it_at = 0; r_fm_wop = 0; r_fm_at = 0;
    r_it_res = '0; r_fm_res = '0; r_snap = '1;
    for (int i = 1; i <= max_cyc; i++) begin
      @(posedge sys_clk);
      if (it_busy) r_it_busy++;
      if (it_wop) begin r_it_wop++; r_it_at = i; r_it_res = {it_idx, it_val}; end
      if (fm_wop) begin r_fm_wop++; r_fm_at = i; r_fm_res = {fm_idx, fm_val}; end
      if ((!it_wop && (it_idx != 0 || it_val != 0)) || (!fm_wop && (fm_idx != 0 || fm_val != 0)))
        dirty_total++;
      if (i == snap_at) r_snap = {it_busy, it_wop, it_idx, it_val};
      op = (i == poke_at);
      if (i == poke_at) begin
        ins_dec_funct3 = 3'd0; reg_rs1_val = 32'd2; reg_rs2_val = 32'd3; reg_rd = 5'd4;
      end
      flush     = (i == flush_at);
      sys_rst_n = (i != rst_at);
    end
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] a, b, e;
    logic [4:0]  rd;
    logic        special;
    logic [31:0] pa[4], pb[4];
    logic [4:0]  prd[4];

    vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, ITER_LAT};
    vecs[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 5'd1,  32'h4000_0000, ITER_LAT};
    vecs[2]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE, ITER_LAT};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFF, ITER_LAT};
    vecs[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         5'd4,  32'hFFFF_FFFD, ITER_LAT};
    vecs[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         5'd6,  32'hFFFF_FFFF, ITER_LAT};
    vecs[6]  = '{3'd5, 32'hFFFF_FFF9,  32'd2,         5'd7,  32'h7FFF_FFFC, ITER_LAT};
    vecs[7]  = '{3'd7, 32'hFFFF_FFF9,  32'd2,         5'd8,  32'd1,         ITER_LAT};
    vecs[8]  = '{3'd4, 32'd5,          32'd0,         5'd9,  32'hFFFF_FFFF, 1};
    vecs[9]  = '{3'd7, 32'd5,          32'd0,         5'd10, 32'd5,         1};
    vecs[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1};
    vecs[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd12, 32'd0,         1};
    vecs[12] = '{3'd5, 32'd5,          32'd0,         5'd13, 32'hFFFF_FFFF, 1};
    vecs[13] = '{3'd6, 32'hFFFF_FFF9,  32'd0,         5'd14, 32'hFFFF_FFF9, 1};
    vecs[14] = '{3'd0, 32'd0,          32'd12345,     5'd15, 32'd0,         ITER_LAT};
    vecs[15] = '{3'd5, 32'hFFFF_FFFF,  32'd1,         5'd31, 32'hFFFF_FFFF, ITER_LAT};

    opc_drive = OPC_OP;
    sys_rst_n = 1'b0; op = 1'b0; flush = 1'b0; ins_dec_op = '0; ins_dec_funct3 = '0;
    ins_dec_funct7 = '0; reg_rs1_val = '0; reg_rs2_val = '0; reg_rd = '0;
    repeat (3) @(posedge sys_clk);
    check("reset it", 64'({it_busy, it_wop, it_idx, it_val}), 64'd0);
    check("reset fm", 64'({fm_busy, fm_wop, fm_idx, fm_val}), 64'd0);
    sys_rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      run_op(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rd, 40, 0, 0, 0, 0);
      check($sformatf("vec%0d result", i), 64'(r_it_res), 64'({vecs[i].rd, vecs[i].exp}));
      check($sformatf("vec%0d latency", i), 64'(r_it_at), 64'(vecs[i].lat));
      check($sformatf("vec%0d busy cycles", i), 64'(r_it_busy),
            64'((vecs[i].lat == 1) ? 0 : XLEN));
      check($sformatf("vec%0d wop count", i), 64'(r_it_wop), 64'd1);
    end

    // Flush on the 10th CALC cycle, then a DIVU one cycle later.
    run_op(3'd4, 32'hFFFF_FC18, 32'd7, 5'd8, 11, 10, 0, 0, 11);
    check("flush busy cycles", 64'(r_it_busy), 64'd10);
    check("flush outputs", 64'(r_snap), 64'd0);
    check("flush wop", 64'(r_it_wop), 64'd0);
    run_op(3'd5, 32'd1000, 32'd7, 5'd9, 40, 0, 0, 0, 0);
    check("post-flush divu", 64'(r_it_res), 64'({5'd9, 32'd142}));
    check("post-flush latency", 64'(r_it_at), 64'(ITER_LAT));
    check("post-flush wop count", 64'(r_it_wop), 64'd1);

    // Strobe during CALC must be dropped.
    run_op(3'd7, 32'd1000, 32'd7, 5'd10, 40, 0, 5, 0, 0);
    check("poke remu", 64'(r_it_res), 64'({5'd10, 32'd6}));
    check("poke wop count", 64'(r_it_wop), 64'd1);
    check("poke latency", 64'(r_it_at), 64'(ITER_LAT));

    // Reset mid-CALC.
    run_op(3'd3, 32'h1234_5678, 32'h9ABC_DEF0, 5'd11, 40, 0, 0, 12, 13);
    check("reset mid-calc outputs", 64'(r_snap), 64'd0);
    check("reset mid-calc wop", 64'(r_it_wop), 64'd0);

    // Wrong opcode is ignored.
    opc_drive = 7'b0010011;
    run_op(3'd0, 32'd3, 32'd4, 5'd12, 40, 0, 0, 0, 0);
    check("bad opcode it", 64'(r_it_wop), 64'd0);
    check("bad opcode fm", 64'(r_fm_wop), 64'd0);
    opc_drive = OPC_OP;

    // Back-to-back fast multiplies, one with rd=0.
    prd[0] = 5'd6; prd[1] = 5'd7; prd[2] = 5'd0; prd[3] = 5'd9;
    for (int k = 0; k < 4; k++) begin
      pa[k] = $urandom; pb[k] = $urandom;
    end
    for (int k = 0; k < 4; k++) begin
      op = 1'b1; ins_dec_op = OPC_OP; ins_dec_funct7 = F7_MD; ins_dec_funct3 = 3'd0;
      reg_rs1_val = pa[k]; reg_rs2_val = pb[k]; reg_rd = prd[k];
      @(posedge sys_clk);
      e = (prd[k] != 0) ? pa[k] * pb[k] : 32'd0;
      check($sformatf("pipe slot%0d", k), 64'({fm_wop, fm_idx, fm_val}),
            64'({(prd[k] != 0), prd[k], e}));
    end
    op = 1'b0;
    @(posedge sys_clk);
    check("pipe drain", 64'(fm_wop), 64'd0);
    repeat (40) @(posedge sys_clk);

    for (int n = 0; n < 60; n++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = pick();
      b  = pick();
      rd = 5'($urandom_range(1, 31));
      e  = ref_model(f3, a, b);
      special = f3[2] && ((b == 0) || (!f3[0] && a == MIN && b == 32'hFFFF_FFFF));
      run_op(f3, a, b, rd, 40, 0, 0, 0, 0);
      check($sformatf("rnd%0d f3=%0d it val", n, f3), 64'(r_it_res), 64'({rd, e}));
      check($sformatf("rnd%0d it latency", n), 64'(r_it_at), 64'(special ? 1 : ITER_LAT));
      check($sformatf("rnd%0d fm val", n), 64'(r_fm_res), 64'({rd, e}));
      check($sformatf("rnd%0d fm latency", n), 64'(r_fm_at),
            64'((special || !f3[2]) ? 1 : ITER_LAT));
    end

    check("idle outputs zero", 64'(dirty_total), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ins_exec_muldiv.md
# ins_exec_muldiv

Parametrised multiply/divide execute unit for the M extension, the multi-cycle companion to the single-cycle integer execute stage. It accepts a decoded R-type instruction with `ins_dec_op = 0110011` and `ins_dec_funct7 = 0000001` plus operand values. It computes the result iteratively, or in one cycle for the fast-multiply and special-case paths. It returns the result on the standard register-write triple and raises `busy` so the pipeline stalls while it works.

## Interface
- `XLEN`, default 32: operand and result width; must be ≥ 8 and even.
- `FAST_MUL`, default 0: 1 selects a single-cycle multiply (registered `*`); 0 selects shift-add iteration, one bit per cycle.
- `sys_clk` in 1: clock. All registers update on the falling edge, matching the execute stage.
- `sys_rst_n` in 1: reset, synchronous and active-low.
- `op` in 1: instruction-valid strobe from decode.
- `ins_dec_op` in 7: opcode.
- `ins_dec_funct3` in 3: selects the operation. 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `ins_dec_funct7` in 7: must be 0000001.
- `reg_rs1_val` in XLEN: operand a.
- `reg_rs2_val` in XLEN: operand b.
- `reg_rd` in 5: destination register index.
- `flush` in 1: synchronous kill of any in-flight operation.
- `busy` out 1: high while an operation is iterating.
- `reg_w_op` out 1: one-cycle register-write strobe.
- `reg_w_reg_idx` out 5: destination index; 0 whenever `reg_w_op` is 0.
- `reg_w_reg_val` out XLEN: result; 0 whenever `reg_w_op` is 0.

## Operation
- **Accept condition:** `op=1`, opcode and funct7 match, state is IDLE or DONE, `flush=0`. All other `op` strobes are ignored.
- **Captured at accept:** funct3, rd, operand magnitudes, and result-sign flags.
- **States:**
  - IDLE → CALC on accept (iterative path).
  - IDLE → DONE on accept (fast path).
  - CALC → DONE when the iteration counter reaches 0.
  - DONE → CALC or DONE on a new accept; otherwise DONE → IDLE.
- **Fast path** (result computed at the accept edge):
  - any multiply when `FAST_MUL=1`;
  - divide/remainder by zero;
  - signed overflow, i.e. DIV/REM with rs1 = most-negative and rs2 = all-ones.
- **Iteration:** counter loads XLEN at accept and decrements each CALC edge.
  - Multiply: shift-add over a 2·XLEN accumulator.
  - Divide: restoring, one quotient bit per edge.
- **Signedness:**
  - Operate on magnitudes. MUL, MULH, DIV and REM treat both operands as signed. MULHSU treats only rs1 as signed. MULHU, DIVU and REMU are unsigned.
  - Apply the sign fix on the edge entering DONE.
  - Product: negate the 2·XLEN product if the operand signs differ.
  - Quotient: negate if the operand signs differ.
  - Remainder: takes the sign of the dividend.
- **Result selection:** MUL returns the low XLEN bits. MULH, MULHSU and MULHU return the high XLEN bits.
- **Special results:**
  - Divide by zero: quotient all-ones; remainder = rs1.
  - Overflow: quotient = most-negative; remainder = 0.
- **Write-back:** `reg_w_op=1` for exactly the one cycle spent in DONE. It is suppressed when rd=0; timing is unchanged in that case.
- **Kill:** `flush=1` or `sys_rst_n=0` → next edge to IDLE, counter cleared, `reg_w_op`/idx/val = 0, and no write-back of the killed operation. Flush has priority over a simultaneous accept.

## Timing
- **Reset values:** state IDLE, `busy=0`, `reg_w_op=0`, `reg_w_reg_idx=0`, `reg_w_reg_val=0`.
- **`busy`:** combinational, `state==CALC`.
- **Iterative latency:** accept at edge N → CALC for edges N+1..N+XLEN. The result is registered at edge N+XLEN. `reg_w_op` is high for the cycle after edge N+XLEN.
- **Fast-path latency:** `reg_w_op` is high for the cycle after the accept edge N.
- **Throughput:**
  - Iterative: one operation per XLEN+1 cycles, since a new accept is allowed while in DONE.
  - Fast path: one per cycle.
- **Ignored strobes:** `op` during CALC is dropped, not queued. Decode must hold the instruction until `busy=0`.

## Test plan
1. **Iterative MUL timing.** XLEN=32, FAST_MUL=0: MUL 7 × 0xFFFFFFFD with rd=5 → `busy` high for exactly 32 cycles; then `reg_w_op` pulses once with idx=5 and val=0xFFFFFFEB.
2. **High-half multiplies.**
   - MULH 0x80000000 × 0x80000000 → 0x40000000.
   - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
   - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
3. **Divide and remainder signs.**
   - DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD.
   - REM of the same operands → 0xFFFFFFFF.
   - DIVU 0xFFFFFFF9 / 2 → 0x7FFFFFFC.
   - REMU of the same operands → 1.
4. **Special cases, each with 1-cycle latency and `busy` never high.**
   - DIV 5 / 0 → 0xFFFFFFFF.
   - REMU 5 / 0 → 5.
   - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
   - REM of the same operands → 0.
5. **Kill and ignored strobes.**
   - Flush on the 10th CALC cycle of a DIV → IDLE on the next edge, `busy=0`, no `reg_w_op`.
   - A DIVU accepted one cycle later completes normally.
   - `op` pulsed mid-CALC → ignored.
   - `sys_rst_n=0` mid-CALC → all outputs 0 on the next edge.
6. **Fast multiply pipelining.** FAST_MUL=1: MUL ops on four consecutive cycles → four consecutive `reg_w_op` pulses, each one cycle after its accept. An rd=0 op in the sequence produces `reg_w_op=0` in its slot.
